// File: rtl/ctrl_datapath.sv
// Control-word driven datapath: four registers fed by a source mux and an ALU,
// with registered status flags and a load counter. R3 is presented as dout.
module ctrl_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       sel,
  input  logic [2:0]       w,
  input  logic [2:0]       s,
  input  logic [3:0]       ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             zf,
  output logic             cf,
  output logic             nf,
  output logic [7:0]       wr_cnt
);

  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic             zf_q, zf_d, cf_q, cf_d, nf_q, nf_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum, diff, shl, shr;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf;
  logic [WIDTH-1:0] src;

  assign op_a = r_q[0];
  assign op_b = r_q[1];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  // One guard bit on each side captures the last bit shifted out; w=0 leaves it 0.
  assign shl  = {1'b0, op_a} << w;
  assign shr  = {op_a, 1'b0} >> w;

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    unique case (s)
      3'd0: alu_res = op_a;
      3'd1: {alu_cf, alu_res} = sum;
      3'd2: {alu_cf, alu_res} = diff;
      3'd3: alu_res = op_a & op_b;
      3'd4: alu_res = op_a | op_b;
      3'd5: alu_res = op_a ^ op_b;
      3'd6: {alu_cf, alu_res} = shl;
      3'd7: {alu_res, alu_cf} = shr;
    endcase
  end

  always_comb begin
    src = din;
    unique case (sel)
      2'd0: src = din;
      2'd1: src = alu_res;
      2'd2: src = {{(WIDTH-3){1'b0}}, w};
      2'd3: src = r_q[w[1:0]];
    endcase
  end

  always_comb begin
    r_d   = r_q;
    zf_d  = zf_q;
    cf_d  = cf_q;
    nf_d  = nf_q;
    cnt_d = cnt_q;
    if (clr) begin
      for (int i = 0; i < 4; i++) r_d[i] = '0;
      zf_d  = 1'b1;
      cf_d  = 1'b0;
      nf_d  = 1'b0;
      cnt_d = '0;
    end else if (|ce) begin
      for (int i = 0; i < 4; i++) begin
        if (ce[i]) r_d[i] = src;
      end
      if (sel == 2'd1) begin
        zf_d = (alu_res == '0);
        cf_d = alu_cf;
        nf_d = alu_res[WIDTH-1];
      end
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      zf_q  <= 1'b1;
      cf_q  <= 1'b0;
      nf_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
      zf_q  <= zf_d;
      cf_q  <= cf_d;
      nf_q  <= nf_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout   = r_q[3];
  assign zf     = zf_q;
  assign cf     = cf_q;
  assign nf     = nf_q;
  assign wr_cnt = cnt_q;

endmodule

// File: doc/ctrl_datapath.md
Name: ctrl_datapath

Overview:
- Datapath stage directly downstream of the lab controller FSM.
- Consumes the per-cycle control word {clr, sel, w, s, ce} and drives four WIDTH-bit registers R0..R3 through a source mux and an ALU.
- Maintains ALU status flags and presents R3 as the block result.
- Purely control-driven: no internal sequencing beyond registers, flags and a write counter.

Parameters:
- WIDTH, 8, datapath width in bits. Minimum 4.

Ports:
- clk    in   1        system clock; all state updates on rising edge
- rst    in   1        synchronous reset, active-low (rst=0 resets on next rising clk edge)
- clr    in   1        synchronous clear of R0..R3, flags and wr_cnt
- sel    in   2        source-bus select: 0=din, 1=ALU result, 2=immediate {0,w}, 3=R[w[1:0]]
- w      in   3        immediate value / register index / shift amount
- s      in   3        ALU op select
- ce     in   4        per-register load enables; ce[i] loads R[i]
- din    in   WIDTH    external data input
- dout   out  WIDTH    current value of R3
- zf     out  1        zero flag
- cf     out  1        carry/borrow flag
- nf     out  1        negative flag (MSB of result)
- wr_cnt out  8        count of cycles with any register load

Behaviour:
- Reset (rst=0 at clock edge): R0..R3=0, zf=1, cf=0, nf=0, wr_cnt=0. Reset overrides clr and ce. dout=0 the cycle after reset.
- Priority: reset > clr > ce.
- clr=1 (rst=1):
  - Same result as reset: all registers 0, zf=1, cf=0, nf=0, wr_cnt=0.
  - ce is ignored that cycle.
- ALU operands: A=R0, B=R1, both combinational from current register values.
- ALU ops on s:
  - 0: A
  - 1: A+B, cf=carry out
  - 2: A-B, cf=borrow (1 when A<B unsigned)
  - 3: A&B
  - 4: A|B
  - 5: A^B
  - 6: A<<w, cf=last bit shifted out; w=0 gives cf=0
  - 7: A>>w logical, cf=last bit shifted out; w=0 gives cf=0
  - Result truncated to WIDTH; wraps modulo 2^WIDTH.
  - Ops 0 and 3-5 force cf=0.
- Immediate source (sel=2): zero-extended w.
- Register-read source (sel=3): R[w[1:0]]; w[2] ignored.
- Load:
  - Every R[i] with ce[i]=1 loads the source bus at the clock edge. Multi-hot ce loads the same value into each enabled register.
  - All loads read pre-edge register values, so R0/R1 used as ALU operands and also loaded in the same cycle use old values.
  - ce=0 holds all registers.
- Latency: one cycle from control word to register/dout update; dout is a registered value, never combinational from din.
- Flags:
  - Update only on cycles with ce!=0 and sel=1; otherwise hold.
  - zf = (ALU result==0); nf = result[WIDTH-1]; cf per op above.
- wr_cnt:
  - Increments by 1 on each non-clr, non-reset cycle with ce!=0.
  - Wraps 255->0.
- Mid-operation reset or clr: takes effect on that edge regardless of in-flight sequence. No partial state survives.
- No X propagation: all outputs driven from registers at all times after first reset.

Test Plan:
- Reset/priority: rst=0 with clr=0, ce=4'hF, sel=0, din=8'hAA for 1 clock -> R0..R3=0, dout=0, zf=1, cf=0, wr_cnt=0. Then rst=1, clr=1, ce=4'hF -> registers stay 0, wr_cnt=0.
- Load and add:
  - sel=2, w=5, ce=4'b0001 -> R0=5.
  - sel=2, w=3, ce=4'b0010 -> R1=3.
  - sel=1, s=1, ce=4'b1000 -> dout=8, zf=0, cf=0, nf=0, wr_cnt=3.
- Borrow, zero and wrap:
  - R0=3, R1=5, s=2, sel=1, ce=4'b1000 -> dout=8'hFE, cf=1, nf=1.
  - Then R0=R1=8'h80, s=1 -> dout=0, zf=1, cf=1.
- Shifts:
  - R0=8'b1000_0001, s=6, w=1 -> dout=8'h02, cf=1.
  - s=7, w=1 -> dout=8'h40, cf=1.
  - w=0 -> dout=8'h81, cf=0.
- Same-cycle and multi-hot:
  - R0=2, R1=3, sel=1, s=1, ce=4'b0001 -> R0=5 (old operands used).
  - sel=0, din=8'h5A, ce=4'b1110 -> R1=R2=R3=8'h5A; flags unchanged.
- Hold, clr and counter:
  - ce=0 for 10 cycles -> registers, flags and wr_cnt unchanged.
  - Drive 256 load cycles -> wr_cnt wraps to 0.
  - clr=1 mid-sequence -> all cleared next edge, zf=1.
